// File: rtl/seq_detector_param_if.sv
// Signal bundle for seq_detector_param: serial stream, pattern programming, and match results.
// The design drives match, out and match_cnt; the front end drives everything else.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int SEL_W = $clog2(NUM_PAT);

  logic               in_valid;
  logic               in;
  logic               overlap_en;
  logic               pat_we;
  logic [SEL_W-1:0]   pat_sel;
  logic [MAX_LEN-1:0] pat_data;
  logic [LEN_W-1:0]   pat_len;
  logic               cnt_clr;
  logic [NUM_PAT-1:0] match;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output in_valid, in, overlap_en, pat_we, pat_sel, pat_data, pat_len, cnt_clr,
    input  match, out, match_cnt
  );

  modport slave (
    input  in_valid, in, overlap_en, pat_we, pat_sel, pat_data, pat_len, cnt_clr,
    output match, out, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial multi-pattern detector with runtime-programmable slots and overlap control.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  seq_detector_param_if.slave  bus
);
  localparam int               LEN_W    = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] pat_q  [NUM_PAT];
  logic [LEN_W-1:0]   len_q  [NUM_PAT];
  logic [LEN_W-1:0]   fill_q [NUM_PAT];
  logic [NUM_PAT-1:0] wr_slot;
  logic [NUM_PAT-1:0] hit_d;
  logic [NUM_PAT-1:0] match_q;
  logic               out_q;

  // Compares only the newest len bits of the history against the slot pattern.
  function automatic logic tail_equal(input logic [MAX_LEN-1:0] h,
                                      input logic [MAX_LEN-1:0] p,
                                      input logic [LEN_W-1:0]   len);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len) && h[i] != p[i]) eq = 1'b0;
    end
    return eq;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hist_next = hist;
    wr_slot   = '0;
    hit_d     = '0;
    if (bus.in_valid) hist_next = {hist[MAX_LEN-2:0], bus.in};
    for (int p = 0; p < NUM_PAT; p++) begin
      wr_slot[p] = bus.pat_we && (int'(bus.pat_sel) == p);
      hit_d[p]   = bus.in_valid && !wr_slot[p]
                && (len_q[p] != '0) && (len_q[p] <= FILL_MAX)
                && (({1'b0, fill_q[p]} + (LEN_W+1)'(1)) >= {1'b0, len_q[p]})
                && tail_equal(hist_next, pat_q[p], len_q[p]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist    <= '0;
      match_q <= '0;
      out_q   <= 1'b0;
      // NOTE: the pattern table is reset, unlike a plain storage array, because its
      // power-on contents define the legacy 1001/010 behaviour.
      for (int p = 0; p < NUM_PAT; p++) begin
        fill_q[p] <= '0;
        pat_q[p]  <= '0;
        len_q[p]  <= '0;
      end
      pat_q[0] <= MAX_LEN'(4'b1001);
      len_q[0] <= LEN_W'(4);
      pat_q[1] <= MAX_LEN'(3'b010);
      len_q[1] <= LEN_W'(3);
    end else begin
      // NOTE: non-blocking assignments make every register see pre-edge values,
      // independent of statement order.
      hist    <= hist_next;
      match_q <= hit_d;
      out_q   <= |hit_d;
      for (int p = 0; p < NUM_PAT; p++) begin
        if (wr_slot[p]) begin
          pat_q[p]  <= bus.pat_data;
          len_q[p]  <= bus.pat_len;
          fill_q[p] <= '0;
        end else if (bus.in_valid) begin
          if (hit_d[p] && !bus.overlap_en) begin
            fill_q[p] <= '0;
          end else if (fill_q[p] != FILL_MAX) begin
            fill_q[p] <= fill_q[p] + LEN_W'(1);
          end
        end
      end
    end
  end

  assign bus.match = match_q;
  assign bus.out   = out_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if ((|hit_d) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.match_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed tables, corner sequences and a
// randomized run against a stream-history reference model.
module tb_seq_detector_param;
  localparam int MAX_LEN = 8;
  localparam int NUM_PAT = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.MAX_LEN(MAX_LEN), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: full list of valid bits since reset, and per slot the index from
  // which bits count as fresh. A slot matches when enough fresh bits exist and the
  // newest len bits spell the pattern.
  bit                 stream [$];
  int                 start_idx [NUM_PAT];
  logic [MAX_LEN-1:0] m_pat [NUM_PAT];
  int                 m_len [NUM_PAT];
  logic [NUM_PAT-1:0] exp_match;
  int                 exp_cnt;

  typedef struct {
    logic       b;
    logic [1:0] m_ov;
    logic [1:0] m_nov;
    int         c_ov;
    int         c_nov;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    stream.delete();
    for (int p = 0; p < NUM_PAT; p++) begin
      start_idx[p] = 0;
      m_pat[p]     = '0;
      m_len[p]     = 0;
    end
    m_pat[0]  = 8'b0000_1001;
    m_len[0]  = 4;
    m_pat[1]  = 8'b0000_0010;
    m_len[1]  = 3;
    exp_match = '0;
    exp_cnt   = 0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic ov, input logic we,
                            input int sel, input logic [MAX_LEN-1:0] data, input int len,
                            input logic clr);
    logic [NUM_PAT-1:0] hits;
    hits = '0;
    if (v) stream.push_back(b);
    for (int p = 0; p < NUM_PAT; p++) begin
      bit wr;
      int n;
      wr = we && (sel == p);
      n  = stream.size();
      if (v && !wr && m_len[p] >= 1 && m_len[p] <= MAX_LEN && (n - start_idx[p]) >= m_len[p]) begin
        hits[p] = 1'b1;
        for (int k = 0; k < m_len[p]; k++)
          if (stream[n-1-k] != m_pat[p][k]) hits[p] = 1'b0;
      end
      if (wr) begin
        m_pat[p]     = data;
        m_len[p]     = len;
        start_idx[p] = n;
      end else if (hits[p] && !ov) begin
        start_idx[p] = n;
      end
    end
    exp_match = hits;
    if (CNT_EN) begin
      if (clr) exp_cnt = 0;
      else if (hits != '0 && exp_cnt < CNT_MAX) exp_cnt++;
    end
  endtask

  // One clock: drive the stream bit, let the edge pass, then compare 1 time unit later.
  task automatic tick(input logic v, input logic b);
    bus.in_valid = v;
    bus.in       = b;
    @(posedge clk);
    model_step(bus.in_valid, bus.in, bus.overlap_en, bus.pat_we, int'(bus.pat_sel),
               bus.pat_data, int'(bus.pat_len), bus.cnt_clr);
    #1;
    check("match", 32'(bus.match), 32'(exp_match));
    check("out", 32'(bus.out), 32'(|exp_match));
    check("match_cnt", 32'(bus.match_cnt), 32'(exp_cnt));
    bus.pat_we  = 1'b0;
    bus.cnt_clr = 1'b0;
  endtask

  task automatic write_slot(input int sel, input logic [MAX_LEN-1:0] data, input int len);
    bus.pat_we   = 1'b1;
    bus.pat_sel  = sel[0];
    bus.pat_data = data;
    bus.pat_len  = len[3:0];
    tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.pat_we   = 1'b0;
    bus.cnt_clr  = 1'b0;
    rstn = 1'b0;
    #2;
    model_reset();
    check("rst_match", 32'(bus.match), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_cnt", 32'(bus.match_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [15:0] prog_bits;
    bus.in_valid   = 1'b0;
    bus.in         = 1'b0;
    bus.overlap_en = 1'b1;
    bus.pat_we     = 1'b0;
    bus.pat_sel    = '0;
    bus.pat_data   = '0;
    bus.pat_len    = '0;
    bus.cnt_clr    = 1'b0;

    tbl[0]  = '{1'b0, 2'b00, 2'b00, 0, 0};
    tbl[1]  = '{1'b1, 2'b00, 2'b00, 0, 0};
    tbl[2]  = '{1'b0, 2'b10, 2'b10, 1, 1};
    tbl[3]  = '{1'b1, 2'b00, 2'b00, 1, 1};
    tbl[4]  = '{1'b0, 2'b10, 2'b00, 2, 1};
    tbl[5]  = '{1'b1, 2'b00, 2'b00, 2, 1};
    tbl[6]  = '{1'b0, 2'b10, 2'b10, 3, 2};
    tbl[7]  = '{1'b0, 2'b00, 2'b00, 3, 2};
    tbl[8]  = '{1'b1, 2'b01, 2'b01, 4, 3};
    tbl[9]  = '{1'b0, 2'b10, 2'b10, 5, 4};
    tbl[10] = '{1'b0, 2'b00, 2'b00, 5, 4};
    tbl[11] = '{1'b1, 2'b01, 2'b00, 6, 4};
    tbl[12] = '{1'b0, 2'b10, 2'b10, 7, 5};
    tbl[13] = '{1'b1, 2'b00, 2'b00, 7, 5};
    tbl[14] = '{1'b1, 2'b00, 2'b00, 7, 5};
    tbl[15] = '{1'b0, 2'b00, 2'b00, 7, 5};

    #1;
    do_reset();

    // Default patterns, overlapping.
    bus.overlap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, tbl[i].b);
      check("tbl_ov_match", 32'(bus.match), 32'(tbl[i].m_ov));
      check("tbl_ov_cnt", 32'(bus.match_cnt), CNT_EN ? 32'(tbl[i].c_ov) : 32'd0);
    end

    // Same stream, non-overlapping.
    do_reset();
    bus.overlap_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, tbl[i].b);
      check("tbl_nov_match", 32'(bus.match), 32'(tbl[i].m_nov));
      check("tbl_nov_cnt", 32'(bus.match_cnt), CNT_EN ? 32'(tbl[i].c_nov) : 32'd0);
    end

    // Overlapping stream with 1-3 idle cycles after every bit.
    do_reset();
    bus.overlap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, tbl[i].b);
      check("gap_match", 32'(bus.match), 32'(tbl[i].m_ov));
      for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
        tick(1'b0, 1'($urandom));
        check("gap_out", 32'(bus.out), 32'd0);
      end
    end

    // Reprogrammed 8-bit pattern in slot 0, slot 1 disabled.
    do_reset();
    write_slot(1, 8'h00, 0);
    write_slot(0, 8'b1011_0111, 8);
    prog_bits = 16'b1011_0111_1011_0111;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, prog_bits[15-i]);
      check("prog_m0", 32'(bus.match[0]), (i == 7 || i == 15) ? 32'd1 : 32'd0);
      check("prog_m1", 32'(bus.match[1]), 32'd0);
    end

    // Reset in the middle of a 1001 sequence discards the partial history.
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    do_reset();
    tick(1'b1, 1'b1);
    check("rst_mid_nomatch", 32'(bus.match), 32'd0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("rst_mid_pre", 32'(bus.match[0]), 32'd0);
    tick(1'b1, 1'b1);
    check("rst_mid_match", 32'(bus.match[0]), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(15) == 0) bus.overlap_en = ~bus.overlap_en;
      if ($urandom_range(49) == 0) bus.cnt_clr = 1'b1;
      if ($urandom_range(19) == 0) begin
        bus.pat_we   = 1'b1;
        bus.pat_sel  = 1'($urandom_range(NUM_PAT - 1));
        bus.pat_data = 8'($urandom);
        bus.pat_len  = 4'($urandom_range(MAX_LEN + 1));
      end
      tick($urandom_range(3) != 0, 1'($urandom));
    end

    // Counter saturation and clear-over-increment priority.
    do_reset();
    bus.overlap_en = 1'b1;
    write_slot(1, 8'h00, 0);
    write_slot(0, 8'h01, 1);
    for (int c = 0; c < 300; c++) tick(1'b1, 1'b1);
    check("cnt_sat", 32'(bus.match_cnt), CNT_EN ? 32'(CNT_MAX) : 32'd0);
    bus.cnt_clr = 1'b1;
    tick(1'b1, 1'b1);
    check("cnt_clr_match", 32'(bus.match[0]), 32'd1);
    check("cnt_clr_zero", 32'(bus.match_cnt), 32'd0);
    tick(1'b1, 1'b1);
    check("cnt_after_clr", 32'(bus.match_cnt), CNT_EN ? 32'd1 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector. It watches a one-bit serial stream and matches it against NUM_PAT runtime-programmable patterns, each up to MAX_LEN bits long. Overlapping or non-overlapping matching is selected at run time, and a saturating counter records match cycles. It is the successor to the fixed 1001/010 detector: out of reset it reproduces that detector's behaviour, and the front end reprograms the patterns as needed.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥4)
- NUM_PAT, 2, number of pattern slots (≥2)
- CNT_W, 8, match counter width
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override)
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  in is sampled this cycle
- in  input  1  serial data bit
- overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping
- pat_we  input  1  write pattern slot
- pat_sel  input  $clog2(NUM_PAT)  slot index for the write
- pat_data  input  MAX_LEN  pattern bits; pat_data[len-1] is the first bit received, pat_data[0] the last
- pat_len  input  LEN_W  pattern length; 0 or >MAX_LEN disables the slot
- cnt_clr  input  1  synchronous clear of match_cnt
- match  output  NUM_PAT  per-slot registered match pulse
- out  output  1  OR of match
- match_cnt  output  CNT_W  saturating count of cycles with out=1

## Operation
- History shift register hist[MAX_LEN-1:0]. When in_valid=1, hist shifts left and in enters hist[0].
- Each slot p has a fill counter fill_p. It increments on every in_valid cycle and saturates at MAX_LEN.
- A slot p matches when all of these hold:
  - in_valid=1
  - the slot is enabled
  - (fill_p+1) ≥ len_p
  - hist_next[len_p-1:0] == pat_p[len_p-1:0]
- Non-overlap (overlap_en=0): on a match of slot p, fill_p is set to 0, so the next match of p needs len_p fresh bits. Other slots are unaffected.
- Overlap (overlap_en=1): fill counters are never reset by a match.
- in_valid=0: hist and fill are held; match and out are 0 in the following cycle.
- Pattern write (pat_we=1):
  - pat_data and pat_len are loaded into slot pat_sel.
  - fill for that slot is cleared.
  - That slot's match is forced to 0 for the same edge.
  - If in_valid=1 in the same cycle, the bit is still shifted into hist.
  - pat_sel ≥ NUM_PAT: the write is ignored.
- Counter: match_cnt increments by 1 per edge at which any slot matches, and saturates at all-ones. cnt_clr=1 clears it to 0 and takes priority over an increment in the same cycle.
- Reset state (rstn=0, immediate):
  - hist=0, all fill=0
  - match=0, out=0, match_cnt=0
  - slot0 = 1001 with len 4; slot1 = 010 with len 3; all other slots len 0
- Reset mid-stream discards partial history. The first match after release needs a full len_p valid bits.
- overlap_en may change on any cycle. It takes effect from the next match decision.

## Timing
- Latency 1: the edge that samples the final pattern bit registers match/out. They stay high for exactly that one cycle unless the next sampled bit also completes a match.
- Back-to-back matches give a continuous high on out with one count per cycle.
- No handshake back-pressure; in_valid may toggle every cycle.

## Configuration
- SEQ_DET_CNT_EN defined: match_cnt and cnt_clr logic are present as described.
- SEQ_DET_CNT_EN undefined: the counter is not instantiated, match_cnt is tied to 0, and cnt_clr is ignored. Match behaviour is unchanged.

## Test plan
- Reset defaults, overlap_en=1:
  - Stimulus: feed bits 0,1,0,1,0,1,0,0,1,0,0,1,0,1,1,0 (indices 0–15) with in_valid=1 every cycle.
  - Response: match[1] after bits 2,4,6,9,12; match[0] after bits 8,11; match_cnt=7 (with SEQ_DET_CNT_EN).
- Same stream with overlap_en=0:
  - Response: match[1] after bits 2,6,9,12; match[0] after bit 8 only; match_cnt=5.
- Insert in_valid=0 gaps of 1–3 cycles between every bit of the first stream:
  - Response: identical match sequence; out=0 during gap cycles.
- Program slot0 with pat_data=8'b1011_0111, len 8, then feed 1,0,1,1,0,1,1,1,1,0,1,1,0,1,1,1:
  - Response: match[0] after bit 7 and bit 15 only.
  - Write slot1 len 0 first: match[1] stays 0 throughout.
- Assert rstn=0 after bits 1,0,0 of a 1001 sequence, then release and feed 1:
  - Response: no match.
  - Then feeding 1,0,0,1 gives a match on the fourth bit.
- Counter edge cases:
  - Force 255 match cycles (CNT_W=8): match_cnt holds at 255.
  - Assert cnt_clr together with a match: match_cnt=0 next cycle.
